// File: rtl/tx_scramble_gearbox_pkg.sv
// Shared PCS definitions: sync headers, error block, scrambler seed and gearbox period.
// Used by the TX scramble/gearbox stage and the 64b/66b encoder.
package tx_scramble_gearbox_pkg;

  localparam logic [1:0]  SYNC_CTRL    = 2'b01;
  localparam logic [1:0]  SYNC_DATA    = 2'b10;
  localparam logic [65:0] ERR_BLOCK    = {{8{8'h1E}}, SYNC_CTRL};
  localparam logic [57:0] SCR_SEED_DEF = 58'h3FF_FFFF_FFFF_FFFF;
  localparam int unsigned GB_PERIOD    = 32'd33;
  localparam int unsigned SEQ_W_DEF    = 32'd6;

  typedef struct packed {
    logic [63:0] payload;
    logic [1:0]  sync;
  } pcs_block_t;

endpackage

// File: rtl/tx_scramble_gearbox_if.sv
// Upstream block handshake between the 64b/66b encoder (master) and the TX scramble/gearbox (slave).
interface tx_scramble_gearbox_if;
  logic [65:0] block_in;
  logic        block_in_valid;
  logic        block_in_ready;

  modport master (output block_in, output block_in_valid, input block_in_ready);
  modport slave  (input block_in, input block_in_valid, output block_in_ready);
endinterface

// File: rtl/pcs_scrambler_58.sv
// Combinational x^58+x^39+1 self-synchronous scrambler over one 64-bit payload (bit 0 first).
// Returns the scrambled payload and the state after the last bit; shared with the RX descrambler.
module pcs_scrambler_58 (
  input  logic [57:0] state_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic [57:0] state_o
);

  // Bit-serial recurrence unrolled; state[0] always holds the newest scrambled bit.
  always_comb begin
    logic [57:0] st_v;
    logic        bit_v;
    st_v   = state_i;
    data_o = 64'h0;
    for (int i = 0; i < 64; i++) begin
      bit_v     = data_i[i] ^ st_v[38] ^ st_v[57];
      data_o[i] = bit_v;
      st_v      = {st_v[56:0], bit_v};
    end
    state_o = st_v;
  end

endmodule

// File: rtl/tx_scramble_gearbox.sv
// 40G PCS TX: scrambles each 66-bit block payload and packs 32 blocks into 33 64-bit words.
// Optional build macro TX_SCR_BYPASS_EN adds the scr_bypass input (payload passed unscrambled).
module tx_scramble_gearbox
  import tx_scramble_gearbox_pkg::*;
#(
  parameter logic [57:0] SCR_SEED = SCR_SEED_DEF,
  parameter int unsigned SEQ_W    = SEQ_W_DEF
) (
  input  logic                        TX_CLK,
  input  logic                        reset,
  tx_scramble_gearbox_if.slave        blk_if,
  output logic [63:0]                 tx_word_out,
  output logic                        tx_word_valid,
  output logic                        underflow_err,
  input  logic                        clear_err
`ifdef TX_SCR_BYPASS_EN
  ,
  input  logic                        scr_bypass
`endif
);

  localparam logic [SEQ_W-1:0] PAUSE_SEQ = SEQ_W'(GB_PERIOD - 32'd1);

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ready_q, ready_d;
  logic [63:0]      resid_q, resid_d;
  logic [57:0]      scr_q, scr_d;
  logic [63:0]      word_q, word_d;
  logic             wvalid_q;
  logic             err_q, err_d;

  logic             bypass_s;
  pcs_block_t       blk_s;
  logic [63:0]      spay_s;
  logic [57:0]      snext_s;
  logic [65:0]      blk_tx_s;
  logic [127:0]     gear_s;

`ifdef TX_SCR_BYPASS_EN
  assign bypass_s = scr_bypass;
`else
  assign bypass_s = 1'b0;
`endif

  // An empty slot (ready but no valid) is filled with the error block.
  assign blk_s = blk_if.block_in_valid ? pcs_block_t'(blk_if.block_in) : pcs_block_t'(ERR_BLOCK);

  pcs_scrambler_58 u_scr (
    .state_i (scr_q),
    .data_i  (blk_s.payload),
    .data_o  (spay_s),
    .state_o (snext_s)
  );

  assign blk_tx_s = {(bypass_s ? blk_s.payload : spay_s), blk_s.sync};
  // Residue bits above 2*seq are always zero, so OR-merge is a plain append.
  assign gear_s   = {64'h0, resid_q} | ({62'h0, blk_tx_s} << {seq_q, 1'b0});

  // Next-state: sequence counter, gearbox packing, scrambler advance, sticky error.
  always_comb begin
    seq_d   = seq_q;
    ready_d = ready_q;
    resid_d = resid_q;
    scr_d   = scr_q;
    word_d  = word_q;
    err_d   = err_q;

    if (seq_q == PAUSE_SEQ) begin
      seq_d = {SEQ_W{1'b0}};
    end else begin
      seq_d = seq_q + SEQ_W'(1);
    end
    ready_d = (seq_d != PAUSE_SEQ);

    if (ready_q) begin
      word_d  = gear_s[63:0];
      resid_d = gear_s[127:64];
      if (bypass_s) begin
        scr_d = scr_q;
      end else begin
        scr_d = snext_s;
      end
    end else begin
      word_d  = resid_q;
      resid_d = 64'h0;
      scr_d   = scr_q;
    end

    if (clear_err) begin
      err_d = 1'b0;
    end else if (ready_q && !blk_if.block_in_valid) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge TX_CLK or negedge reset) begin
    if (!reset) begin
      seq_q    <= {SEQ_W{1'b0}};
      ready_q  <= 1'b1;
      resid_q  <= 64'h0;
      scr_q    <= SCR_SEED;
      word_q   <= 64'h0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      ready_q  <= ready_d;
      resid_q  <= resid_d;
      scr_q    <= scr_d;
      word_q   <= word_d;
      wvalid_q <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign blk_if.block_in_ready = ready_q;
  assign tx_word_out           = word_q;
  assign tx_word_valid         = wvalid_q;
  assign underflow_err         = err_q;

endmodule

// File: tb/tb_tx_scramble_gearbox.sv
// Scoreboard bench for tx_scramble_gearbox: a bit-queue gearbox model plus bench scrambler/descrambler.
// With TX_SCR_BYPASS_EN defined the bypass scenario is also exercised.
module tb_tx_scramble_gearbox;
  import tx_scramble_gearbox_pkg::*;

  logic        TX_CLK = 1'b0;
  logic        reset;
  logic [63:0] tx_word_out;
  logic        tx_word_valid;
  logic        underflow_err;
  logic        clear_err;
  bit          m_bypass = 1'b0;

  tx_scramble_gearbox_if u_if ();

`ifdef TX_SCR_BYPASS_EN
  logic scr_bypass;
  assign scr_bypass = m_bypass;
`endif

  tx_scramble_gearbox dut (
    .TX_CLK        (TX_CLK),
    .reset         (reset),
    .blk_if        (u_if),
    .tx_word_out   (tx_word_out),
    .tx_word_valid (tx_word_valid),
    .underflow_err (underflow_err),
    .clear_err     (clear_err)
`ifdef TX_SCR_BYPASS_EN
    ,
    .scr_bypass    (scr_bypass)
`endif
  );

  always #5 TX_CLK = ~TX_CLK;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [57:0] m_scr;
  logic [57:0] d_scr;
  int          m_seq;
  bit          m_err;
  bit          bitq[$];
  bit          rxq[$];
  logic [63:0] expq[$];
  logic [65:0] sentq[$];
  logic [63:0] last_word;

  function automatic logic [121:0] scr_model(input logic [63:0] d, input logic [57:0] s_in, input bit descr);
    logic [57:0] s;
    logic [63:0] o;
    s = s_in;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ s[38] ^ s[57];
      s    = {s[56:0], (descr ? d[i] : o[i])};
    end
    return {s, o};
  endfunction

  task automatic model_reset();
    m_scr = SCR_SEED_DEF;
    d_scr = SCR_SEED_DEF;
    m_seq = 0;
    m_err = 1'b0;
    bitq.delete();
    rxq.delete();
    expq.delete();
    sentq.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge TX_CLK);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, push expectations, then pop and compare the DUT output.
  task automatic drive_cycle(input bit v, input logic [65:0] blk, input bit clr, output bit rdy_seen);
    logic [65:0]  b;
    logic [65:0]  sb;
    logic [121:0] r;
    logic [63:0]  w;
    logic [63:0]  ew;
    logic [65:0]  rb;
    u_if.block_in_valid = v;
    u_if.block_in       = blk;
    clear_err           = clr;
    rdy_seen            = u_if.block_in_ready;
    chk_cnt++;
    if (rdy_seen !== (m_seq != 32)) $display("FAIL ready seq=%0d got=%b exp=%b", m_seq, rdy_seen, (m_seq != 32));
    else pass_cnt++;
    if (m_seq != 32) begin
      b = v ? blk : ERR_BLOCK;
      sentq.push_back(b);
      if (m_bypass) r = {m_scr, b[65:2]};
      else r = scr_model(b[65:2], m_scr, 1'b0);
      m_scr = r[121:64];
      sb = {r[63:0], b[1:0]};
      for (int i = 0; i < 66; i++) bitq.push_back(sb[i]);
    end
    m_err = clr ? 1'b0 : (m_err | ((m_seq != 32) && !v));
    w = 64'h0;
    for (int i = 0; i < 64; i++) w[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
    expq.push_back(w);
    m_seq = (m_seq == 32) ? 0 : m_seq + 1;
    @(posedge TX_CLK);
    #1;
    ew = expq.pop_front();
    chk_cnt++;
    if (tx_word_valid !== 1'b1) $display("FAIL word_valid got=%b exp=1", tx_word_valid);
    else pass_cnt++;
    chk_cnt++;
    if (tx_word_out !== ew) $display("FAIL word got=%h exp=%h", tx_word_out, ew);
    else pass_cnt++;
    chk_cnt++;
    if (underflow_err !== m_err) $display("FAIL underflow_err got=%b exp=%b", underflow_err, m_err);
    else pass_cnt++;
    last_word = tx_word_out;
    for (int i = 0; i < 64; i++) rxq.push_back(tx_word_out[i]);
    while (rxq.size() >= 66 && sentq.size() > 0) begin
      for (int i = 0; i < 66; i++) rb[i] = rxq.pop_front();
      if (!m_bypass) begin
        r = scr_model(rb[65:2], d_scr, 1'b1);
        d_scr = r[121:64];
        rb[65:2] = r[63:0];
      end
      b = sentq.pop_front();
      chk_cnt++;
      if (rb !== b) $display("FAIL descramble got=%h exp=%h", rb, b);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    bit rdy;
    reset = 1'b0;
    u_if.block_in_valid = 1'b0;
    u_if.block_in = 66'h0;
    clear_err = 1'b0;
    repeat (3) @(posedge TX_CLK);
    #1;
    chk_cnt++;
    if (tx_word_out !== 64'h0) $display("FAIL rst_word got=%h exp=0", tx_word_out); else pass_cnt++;
    chk_cnt++;
    if (tx_word_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", tx_word_valid); else pass_cnt++;
    chk_cnt++;
    if (u_if.block_in_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", u_if.block_in_ready); else pass_cnt++;
    chk_cnt++;
    if (underflow_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", underflow_err); else pass_cnt++;
    reset = 1'b1;
    model_reset();
    drive_cycle(1'b1, {64'h0123_4567_89AB_CDEF, SYNC_DATA}, 1'b0, rdy);
  endtask

  task automatic test_pause_slots();
    bit rdy;
    int acc;
    apply_reset();
    acc = 0;
    for (int cyc = 1; cyc <= 99; cyc++) begin
      drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
      chk_cnt++;
      if (rdy !== ((cyc % 33) != 0)) $display("FAIL pause cyc=%0d got=%b exp=%b", cyc, rdy, ((cyc % 33) != 0));
      else pass_cnt++;
      if (rdy) acc++;
    end
    chk_cnt++;
    if (acc != 96) $display("FAIL accepted got=%0d exp=96", acc); else pass_cnt++;
  endtask

  task automatic test_scramble();
    bit rdy;
    int acc;
    logic [65:0] rb;
    apply_reset();
    for (int i = 0; i < 66; i++) drive_cycle(1'b1, {64'h0, SYNC_DATA}, 1'b0, rdy);
    acc = 0;
    while (acc < 1000) begin
      rb = {$urandom(), $urandom(), SYNC_DATA};
      if ($urandom_range(0, 1) == 1) rb[1:0] = SYNC_CTRL;
      drive_cycle(1'b1, rb, 1'b0, rdy);
      if (rdy) acc++;
    end
    chk_cnt++;
    if (sentq.size() > 1) $display("FAIL rx_backlog got=%0d exp<=1", sentq.size()); else pass_cnt++;
  endtask

  task automatic test_underflow();
    bit rdy;
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
    drive_cycle(1'b0, {64'hDEAD_BEEF_0000_0000, SYNC_DATA}, 1'b0, rdy);
    chk_cnt++;
    if (underflow_err !== 1'b1) $display("FAIL err_set got=%b exp=1", underflow_err); else pass_cnt++;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
    chk_cnt++;
    if (underflow_err !== 1'b1) $display("FAIL err_held got=%b exp=1", underflow_err); else pass_cnt++;
    drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b1, rdy);
    chk_cnt++;
    if (underflow_err !== 1'b0) $display("FAIL err_clear got=%b exp=0", underflow_err); else pass_cnt++;
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
    drive_cycle(1'b0, 66'h0, 1'b1, rdy);
    chk_cnt++;
    if (underflow_err !== 1'b0) $display("FAIL err_clear_wins got=%b exp=0", underflow_err); else pass_cnt++;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
  endtask

  task automatic test_mid_reset();
    bit rdy;
    apply_reset();
    for (int i = 0; i < 17; i++) drive_cycle((i != 3), {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (tx_word_out !== 64'h0) $display("FAIL mid_rst_word got=%h exp=0", tx_word_out); else pass_cnt++;
    chk_cnt++;
    if (tx_word_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", tx_word_valid); else pass_cnt++;
    chk_cnt++;
    if (underflow_err !== 1'b0) $display("FAIL mid_rst_err got=%b exp=0", underflow_err); else pass_cnt++;
    chk_cnt++;
    if (u_if.block_in_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", u_if.block_in_ready); else pass_cnt++;
    @(posedge TX_CLK);
    #1;
    reset = 1'b1;
    model_reset();
    drive_cycle(1'b1, {64'hA5A5_5A5A_0F0F_F0F0, SYNC_CTRL}, 1'b0, rdy);
    chk_cnt++;
    if (last_word[1:0] !== SYNC_CTRL) $display("FAIL restart_sync got=%b exp=%b", last_word[1:0], SYNC_CTRL);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, {$urandom(), $urandom(), SYNC_DATA}, 1'b0, rdy);
  endtask

`ifdef TX_SCR_BYPASS_EN
  task automatic test_bypass();
    bit rdy;
    logic [65:0] raw;
    logic [63:0] w1_exp;
    raw = {64'h0000_0000_0100_004B, SYNC_CTRL};
    w1_exp = {raw[61:0], raw[65:64]};
    m_bypass = 1'b1;
    apply_reset();
    drive_cycle(1'b1, raw, 1'b0, rdy);
    drive_cycle(1'b1, raw, 1'b0, rdy);
    chk_cnt++;
    if (last_word !== w1_exp) $display("FAIL bypass_word1 got=%h exp=%h", last_word, w1_exp); else pass_cnt++;
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, raw, 1'b0, rdy);
    m_bypass = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pause_slots();
    test_scramble();
    test_underflow();
    test_mid_reset();
`ifdef TX_SCR_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
